mov_exec_fsm: RTL
=================

Name: mov_exec_fsm

Overview:
- Parametrised execution sequencer for the register-move instruction class (MOVI immediate-to-register, MOV register-to-register) of the microcontroller datapath.
- Latches one 16-bit instruction on a start handshake and sequences PC increment, bus drive, register write enable and completion.
- Supports an arbitrary register-file size, data width and zero- or sign-extension of the immediate, and flags illegal register indices.

Parameters:
- DATA_W, 16, bus/register data width; must be >= IMM_W.
- NUM_REGS, 4, number of general registers, 1..64.
- IMM_W, 6, immediate field width taken from instr[IMM_W-1:0]; must be <= 6.
- SIGN_EXT, 0, 1 = sign-extend the immediate to DATA_W; 0 = zero-extend.
- OPC_MOVI, 4'b0111, opcode value for MOVI.
- OPC_MOV, 4'b0110, opcode value for MOV.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request to execute instr; sampled only in IDLE.
- instr  in  16  instruction: [15:12] opcode, [11:6] dest index, [5:0] immediate (MOVI) or source index (MOV).
- busy  out  1  high in every state except IDLE.
- pc_inc  out  1  one-cycle program-counter increment.
- imm_oe  out  1  immediate drives the bus.
- imm_data  out  DATA_W  extended immediate; 0 whenever imm_oe=0.
- reg_out  out  NUM_REGS  one-hot source-register bus drive (MOV).
- reg_in  out  NUM_REGS  one-hot destination-register load enable.
- done  out  1  one-cycle completion pulse.
- err  out  1  asserted with done when an index was illegal.

Behaviour:
- Reset: state=IDLE, latched instruction=0, all outputs 0. Asynchronous; reset mid-instruction aborts immediately with no further pc_inc, reg_in or done.
- Outputs are a Moore decode of the registered state plus the latched instruction. Nothing is combinational from start or instr after the latch.
- States: IDLE, FETCH, DRIVE, WRITE, DONE.
- IDLE: start=1 with opcode OPC_MOVI or OPC_MOV latches instr and goes to FETCH. Any other opcode is ignored: stay in IDLE, no outputs. start=0 stays in IDLE.
- Legality check at latch: dest >= NUM_REGS is illegal; for MOV, src >= NUM_REGS is also illegal. The result is stored as an illegal flag.
- FETCH: pc_inc=1. Next state is DRIVE if legal, otherwise DONE.
- DRIVE:
  - MOVI: imm_oe=1, imm_data=extend(instr[IMM_W-1:0]).
  - MOV: reg_out[src]=1.
  - reg_in=0. Next state WRITE.
- WRITE: same bus drive as DRIVE, plus reg_in[dest]=1 for exactly one cycle. Next state DONE.
- DONE: done=1, err=illegal flag, bus drives 0. Next state IDLE.
- Latency from the start edge: pc_inc in cycle 1, drive in cycle 2, reg_in in cycle 3, done in cycle 4, IDLE (busy=0) in cycle 5. Illegal path: pc_inc in cycle 1, done+err in cycle 2.
- start while busy is ignored. Changes on instr while busy have no effect.
- start asserted in the cycle busy falls is accepted: back-to-back issue, no gap cycle required.
- MOV with src==dest is legal: reg_out and reg_in target the same register; the result is a no-op write.
- Extension: SIGN_EXT=1 replicates instr[IMM_W-1] into the upper bits; SIGN_EXT=0 fills them with 0. Bits [5:IMM_W] are ignored when IMM_W<6.
- reg_in and reg_out are never asserted with more than one bit set. imm_oe and reg_out are never active together.

Test Plan:
- Reset then MOVI: instr=16'h7085 (dest 2, imm 5), start pulse -> pc_inc in cycle 1; imm_oe=1 and imm_data=16'h0005 in cycles 2-3; reg_in=4'b0100 in cycle 3 only; done in cycle 4; busy low in cycle 5; err=0.
- Sign extension: SIGN_EXT=1, instr=16'h703F (dest 0, imm 6'h3F) -> imm_data=16'hFFFF. Same stimulus with SIGN_EXT=0 -> imm_data=16'h003F.
- MOV: instr=16'h60C1 (dest 3, src 1) -> reg_out=4'b0010 in cycles 2-3, reg_in=4'b1000 in cycle 3, imm_oe=0 throughout, done in cycle 4.
- Illegal index: NUM_REGS=4, instr=16'h7145 (dest 5) -> pc_inc in cycle 1; done=1 and err=1 in cycle 2; reg_in, imm_oe and reg_out stay 0 throughout.
- Handshake edges:
  - start held high with an unrelated opcode 4'h3 -> remains IDLE.
  - Second start mid-instruction -> ignored.
  - start in the cycle busy falls -> new instruction accepted, pc_inc the following cycle.
- Reset mid-operation: assert rst during WRITE -> all outputs 0 immediately; no done pulse; next start executes normally.

Source files
------------

// File: rtl/mov_exec_fsm.sv
// mov_exec_fsm
// Execution sequencer for the register-move instruction class (MOVI, MOV).
// A start handshake in IDLE latches one 16-bit instruction. The block then
// steps through FETCH (pc increment), DRIVE (bus drive), WRITE (bus drive plus
// a destination load enable) and DONE (completion pulse).
// An instruction with an illegal register index goes straight from FETCH to
// DONE and raises err. All outputs are registered and depend only on the
// state and the latched instruction.

module mov_exec_fsm #(
  parameter int         DATA_W   = 16,
  parameter int         NUM_REGS = 4,
  parameter int         IMM_W    = 6,
  parameter bit         SIGN_EXT = 1'b0,
  parameter logic [3:0] OPC_MOVI = 4'b0111,
  parameter logic [3:0] OPC_MOV  = 4'b0110
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         instr,
  output logic                busy,
  output logic                pc_inc,
  output logic                imm_oe,
  output logic [DATA_W-1:0]   imm_data,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRIVE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Register count as a 7-bit value so it can be compared with 6-bit indices.
  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  // Widen the immediate field to DATA_W. Field bits at IMM_W and above are
  // ignored. With SIGN_EXT set, the top immediate bit fills the upper bits.
  function automatic logic [DATA_W-1:0] extend_imm(input logic [5:0] field);
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] upper_mask;
    value            = {DATA_W{1'b0}};
    upper_mask       = {DATA_W{1'b1}} << IMM_W;
    value[IMM_W-1:0] = field[IMM_W-1:0];
    if (SIGN_EXT && field[IMM_W-1]) begin
      value = value | upper_mask;
    end else begin
      value = value;
    end
    return value;
  endfunction

  // Turn a register index into a one-hot vector. An out-of-range index gives
  // all zeros, so the result can never have more than one bit set.
  function automatic logic [NUM_REGS-1:0] onehot_idx(input logic [5:0] idx);
    logic [NUM_REGS-1:0] vec;
    vec = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 6'(i)) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

  state_t      state_r;
  logic [15:0] instr_r;
  logic        illegal_r;

  logic                new_is_movi_s;
  logic                new_is_mov_s;
  logic                new_accept_s;
  logic                new_illegal_s;
  logic                lat_is_movi_s;
  logic [DATA_W-1:0]   imm_ext_s;
  logic [NUM_REGS-1:0] src_oh_s;
  logic [NUM_REGS-1:0] dst_oh_s;

  // Decode the incoming instruction: is it accepted, and are its indices legal.
  always_comb begin
    new_is_movi_s = 1'b0;
    new_is_mov_s  = 1'b0;
    new_illegal_s = 1'b0;
    if (instr[15:12] == OPC_MOVI) begin
      new_is_movi_s = 1'b1;
    end else if (instr[15:12] == OPC_MOV) begin
      new_is_mov_s = 1'b1;
    end else begin
      new_is_movi_s = 1'b0;
      new_is_mov_s  = 1'b0;
    end
    new_accept_s = start && (new_is_movi_s || new_is_mov_s);
    if ({1'b0, instr[11:6]} >= NUM_REGS_W) begin
      new_illegal_s = 1'b1;
    end else if (new_is_mov_s && ({1'b0, instr[5:0]} >= NUM_REGS_W)) begin
      new_illegal_s = 1'b1;
    end else begin
      new_illegal_s = 1'b0;
    end
  end

  // Work out the bus values from the latched instruction only.
  always_comb begin
    lat_is_movi_s = (instr_r[15:12] == OPC_MOVI);
    imm_ext_s     = extend_imm(instr_r[5:0]);
    src_oh_s      = onehot_idx(instr_r[5:0]);
    dst_oh_s      = onehot_idx(instr_r[11:6]);
  end

  // Sequencer state, instruction latch and registered Moore outputs. Each
  // branch loads the outputs of the state it moves into.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      instr_r   <= 16'h0000;
      illegal_r <= 1'b0;
      busy      <= 1'b0;
      pc_inc    <= 1'b0;
      imm_oe    <= 1'b0;
      imm_data  <= {DATA_W{1'b0}};
      reg_out   <= {NUM_REGS{1'b0}};
      reg_in    <= {NUM_REGS{1'b0}};
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      pc_inc   <= 1'b0;
      imm_oe   <= 1'b0;
      imm_data <= {DATA_W{1'b0}};
      reg_out  <= {NUM_REGS{1'b0}};
      reg_in   <= {NUM_REGS{1'b0}};
      done     <= 1'b0;
      err      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (new_accept_s) begin
            instr_r   <= instr;
            illegal_r <= new_illegal_s;
            state_r   <= ST_FETCH;
            busy      <= 1'b1;
            pc_inc    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_FETCH: begin
          busy <= 1'b1;
          if (illegal_r) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            state_r <= ST_DRIVE;
            if (lat_is_movi_s) begin
              imm_oe   <= 1'b1;
              imm_data <= imm_ext_s;
            end else begin
              reg_out <= src_oh_s;
            end
          end
        end
        ST_DRIVE: begin
          state_r <= ST_WRITE;
          busy    <= 1'b1;
          reg_in  <= dst_oh_s;
          if (lat_is_movi_s) begin
            imm_oe   <= 1'b1;
            imm_data <= imm_ext_s;
          end else begin
            reg_out <= src_oh_s;
          end
        end
        ST_WRITE: begin
          state_r <= ST_DONE;
          busy    <= 1'b1;
          done    <= 1'b1;
          err     <= illegal_r;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
